// File: rtl/demux1to32_reg_n.sv
// 32-entry, n-bit register bank written through a two-stage pipelined
// 1-to-32 demultiplexer. Stage 1 decodes the group and captures the request;
// stage 2 decodes the entry within the group and commits the write.
module demux1to32_reg_n #(
   parameter int n       = 4,
   parameter bit ZERO_E0 = 1'b1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         wr_en_i,
   input  logic [4:0]   wr_addr_i,
   input  logic [n-1:0] wr_data_i,
   output logic [n-1:0] data_o [0:31],
   output logic         busy_o,
   output logic         wr_done_o
);

   logic         vld_p1;
   logic [3:0]   grp_oh_p1;
   logic [2:0]   sel_p1;
   logic [n-1:0] data_p1;
   logic         zero_p1;
   logic [31:0]  we_p1;

   // 2-bit to one-hot group decode
   function automatic logic [3:0] grp_decode(input logic [1:0] grp);
      grp_decode = 4'b0001 << grp;
   endfunction

   // Stage 1: capture request, decode group; group one-hot is cleared when idle
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_p1    <= 1'b0;
         grp_oh_p1 <= 4'b0000;
         sel_p1    <= 3'd0;
         data_p1   <= '0;
         zero_p1   <= 1'b0;
      end else begin
         vld_p1    <= wr_en_i;
         grp_oh_p1 <= wr_en_i ? grp_decode(wr_addr_i[4:3]) : 4'b0000;
         sel_p1    <= wr_addr_i[2:0];
         data_p1   <= wr_data_i;
         zero_p1   <= (wr_addr_i == 5'd0) && ZERO_E0;
      end
   end

   // Stage 2 decode: per-entry write enable, fully determined by stage-1 state
   always_comb begin
      we_p1 = 32'd0;
      for (int g = 0; g < 4; g++) begin
         for (int e = 0; e < 8; e++) begin
            we_p1[g*8+e] = vld_p1 && grp_oh_p1[g] && (sel_p1 == 3'(e)) && !zero_p1;
         end
      end
   end

   // Stage 2: commit the write into the selected entry
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 32; i++) begin
            data_o[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 32; i++) begin
            if (we_p1[i]) begin
               data_o[i] <= data_p1;
            end
         end
      end
   end

   // Stage 2: completion pulse, including discarded entry-0 writes
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_done_o <= 1'b0;
      end else begin
         wr_done_o <= vld_p1;
      end
   end

   assign busy_o = vld_p1;

endmodule

// File: tb/tb_demux1to32_reg_n.sv
// Scoreboard bench: the driver updates an array model per request and queues
// the expected bank image; the monitor pops one image per expected completion
// and compares every entry, busy and done on each falling edge.
module tb_demux1to32_reg_n;

   localparam int N = 4;

   typedef struct packed {
      logic [32*N-1:0] img1;
      logic [32*N-1:0] img0;
   } exp_t;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic         wr_en_i = 1'b0;
   logic [4:0]   wr_addr_i = 5'd0;
   logic [N-1:0] wr_data_i = '0;
   logic [N-1:0] data1 [0:31];
   logic [N-1:0] data0 [0:31];
   logic         busy1, busy0, done1, done0;

   int checks = 0;
   int failures = 0;

   logic [N-1:0] m1 [32];
   logic [N-1:0] m0 [32];
   exp_t         q[$];
   logic [32*N-1:0] cur1 = '0;
   logic [32*N-1:0] cur0 = '0;

   demux1to32_reg_n #(.n(N), .ZERO_E0(1'b1)) dut1 (
      .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
      .wr_data_i(wr_data_i), .data_o(data1), .busy_o(busy1), .wr_done_o(done1));

   demux1to32_reg_n #(.n(N), .ZERO_E0(1'b0)) dut0 (
      .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
      .wr_data_i(wr_data_i), .data_o(data0), .busy_o(busy0), .wr_done_o(done0));

   always #5 clk_i = ~clk_i;

   function automatic logic [32*N-1:0] pack(input logic [N-1:0] a [0:31]);
      logic [32*N-1:0] p;
      for (int i = 0; i < 32; i++) p[i*N +: N] = a[i];
      return p;
   endfunction

   task automatic chk(input string name, input logic [32*N-1:0] act, input logic [32*N-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         m1[i] = '0;
         m0[i] = '0;
      end
   endtask

   // Issue one request; it is sampled on the following rising edge
   task automatic wr(input logic en, input logic [4:0] addr, input logic [N-1:0] d);
      exp_t e;
      @(posedge clk_i);
      #1;
      wr_en_i   = en;
      wr_addr_i = addr;
      wr_data_i = d;
      if (en) begin
         if (addr != 5'd0) m1[addr] = d;
         m0[addr] = d;
         for (int i = 0; i < 32; i++) begin
            e.img1[i*N +: N] = m1[i];
            e.img0[i*N +: N] = m0[i];
         end
         q.push_back(e);
      end
   endtask

   // Assert reset just after an edge, check it acts at once, release after next edge
   task automatic do_reset();
      @(posedge clk_i);
      #1;
      rst_ni  = 1'b0;
      wr_en_i = 1'b0;
      #1;
      chk("rst_data1", pack(data1), '0);
      chk("rst_data0", pack(data0), '0);
      chk("rst_busy", {busy1, busy0}, '0);
      chk("rst_done", {done1, done0}, '0);
      model_clear();
      q.delete();
      cur1 = '0;
      cur0 = '0;
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   // Monitor: expected busy/done follow accepted requests; data changes only on completion
   initial begin
      logic en_s, exp_busy, prev_busy, exp_done;
      exp_t e;
      prev_busy = 1'b0;
      forever begin
         @(posedge clk_i);
         en_s = wr_en_i & rst_ni;
         @(negedge clk_i);
         exp_busy = en_s & rst_ni;
         exp_done = prev_busy & rst_ni;
         if (exp_done) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_empty actual=empty required=entry");
            end else begin
               e = q.pop_front();
               cur1 = e.img1;
               cur0 = e.img0;
            end
         end
         chk("busy", {busy1, busy0}, {exp_busy, exp_busy});
         chk("done", {done1, done0}, {exp_done, exp_done});
         chk("bank_z1", pack(data1), cur1);
         chk("bank_z0", pack(data0), cur0);
         prev_busy = exp_busy;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "timeout");
   end

   initial begin
      model_clear();
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;

      // preload then reset
      wr(1'b1, 5'd5, 4'h6);
      wr(1'b1, 5'd31, 4'hC);
      wr(1'b0, 5'd0, 4'h0);
      wr(1'b0, 5'd0, 4'h0);
      wr(1'b0, 5'd0, 4'h0);
      do_reset();

      // single write
      wr(1'b1, 5'd13, 4'hA);
      repeat (3) wr(1'b0, 5'd13, 4'h5);

      // back-to-back sweep 31..0
      for (int k = 31; k >= 0; k--) wr(1'b1, 5'(k), 4'(k));
      repeat (3) wr(1'b0, 5'd0, 4'hF);

      // same-address collision
      wr(1'b1, 5'd8, 4'h3);
      wr(1'b1, 5'd8, 4'h7);
      repeat (3) wr(1'b0, 5'd8, 4'h1);

      // entry-0 policy
      wr(1'b1, 5'd0, 4'hF);
      repeat (3) wr(1'b0, 5'd0, 4'h2);

      // reset mid-pipeline
      wr(1'b1, 5'd20, 4'h9);
      do_reset();
      repeat (3) wr(1'b0, 5'd20, 4'h9);

      // randomized traffic, including disabled cycles with live addr/data
      for (int i = 0; i < 400; i++) begin
         wr(($urandom_range(0, 3) != 0), 5'($urandom), 4'($urandom));
      end
      repeat (4) wr(1'b0, 5'($urandom), 4'($urandom));

      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL sb_drain actual=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/demux1to32_reg_n.md
# demux1to32_reg_n

Write-side companion to the 32-to-1 read multiplexer: a 32-entry, n-bit register bank whose single write port is steered by a two-stage pipelined 1-to-32 demultiplexer. Stage 1 decodes the upper address bits to one of 4 groups. Stage 2 decodes the lower bits to one of 8 entries in that group and commits the write. All 32 entries are exposed in parallel on an unpacked array output, which drives the data input of the 32-to-1 read mux in the register-file datapath.

## Interface
- n, 4: entry width in bits.
- ZERO_E0, 1: when 1, entry 0 is hardwired to zero and writes to it are discarded. When 0, entry 0 is an ordinary entry.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- wr_en_i  input  1  write request, sampled every rising edge.
- wr_addr_i  input  5  target entry index, 0..31.
- wr_data_i  input  n  write data.
- data_o  output  n x [0:31]  current contents of all entries, registered.
- busy_o  output  1  stage 1 holds a write that has not yet committed.
- wr_done_o  output  1  one-cycle pulse: a write committed on the previous edge.

## Operation
- Address split:
  - wr_addr_i[4:3] selects the group, 0..3.
  - wr_addr_i[2:0] selects the entry within the group.
  - Entry index = group*8 + entry.
- Stage 1, on each rising edge:
  - Register s1_valid = wr_en_i.
  - Register s1_grp_oh = 4-bit one-hot of addr[4:3]; all-zero when wr_en_i=0.
  - Register s1_sel = addr[2:0], s1_data = wr_data_i, s1_zero = (addr==0 && ZERO_E0).
- Stage 2, on each rising edge:
  - For each group g, an 8-way one-hot decode of s1_sel, gated by s1_grp_oh[g] and s1_valid, produces the per-entry write enable.
  - The enabled entry loads s1_data.
  - If s1_zero is set, no entry is written.
- wr_done_o is registered from s1_valid. It pulses for every accepted request, including discarded writes to entry 0.
- busy_o = s1_valid.
- No backpressure: a request is accepted every cycle wr_en_i=1. The pipeline never stalls and never drops a request, apart from the entry-0 discard.
- At most one entry changes per edge.
- Writes with wr_en_i=0 leave all entries unchanged, regardless of wr_addr_i and wr_data_i.
- The decode contains no X-propagation paths. Every entry's write enable is a fully specified function of the registered stage-1 state.

## Timing
- Reset (rst_ni=0), asynchronous, takes effect without a clock edge:
  - All data_o entries = 0.
  - s1_valid = 0, busy_o = 0, wr_done_o = 0.
  - s1_grp_oh = 0; s1_sel and s1_data = 0.
- Reset asserted mid-operation: a write held in stage 1 is lost. It must not commit after reset releases, and no wr_done_o pulse follows.
- First accepted edge after release: normal operation, no dead cycles.
- Latency:
  - Request sampled at edge E.
  - Entry updated at edge E+1; the new value is visible on data_o in the cycle after E+1.
  - wr_done_o is high for the cycle after E+1, aligned with the new value being visible.
- Throughput: one write per cycle. Back-to-back writes to the same entry commit in order, so the last one wins at E+2.
- Back-to-back writes to different entries each commit one edge after their own stage-1 edge. Groups do not interact.
- Read-during-write: the old value remains on data_o until the commit edge. There is no bypass from wr_data_i to data_o.
- Stage-2 writes and new stage-1 captures occur on the same edge without conflict.

## Test plan
- Reset values: preload entries 5 and 31, then pulse rst_ni low between edges -> all data_o = 0 immediately; busy_o = 0, wr_done_o = 0.
- Single write, n=4: wr_en_i=1, addr=13, data=4'hA at edge E -> at E: busy_o = 1; at E+1: data_o[13] = A, other entries 0; wr_done_o = 1 for exactly one cycle.
- Back-to-back sweep: writes addr k with data k (mod 16) for k=31..0 on consecutive edges -> after the final commit, data_o[k] = k mod 16 for k ≥ 1; data_o[0] = 0 with ZERO_E0=1; 32 wr_done_o pulses.
- Same-address collision: writes to addr 8 with data 3 then 7 on consecutive edges -> data_o[8] = 3 for one cycle, then 7; all other entries unchanged.
- Entry-0 policy:
  - ZERO_E0=1: write data=F to addr 0 -> data_o[0] stays 0; wr_done_o still pulses.
  - ZERO_E0=0: the same write -> data_o[0] = F at E+1.
- Reset mid-pipeline: write addr 20, data=9 at E; assert rst_ni before E+1; release after E+1 -> data_o[20] = 0, no wr_done_o pulse.
